// File: rtl/count_bcd_conv.sv
// count_bcd_conv: serial binary-to-BCD converter (shift-and-add-3, one bit
// per clock) for an 8-bit counter value, with an optional multiplexed
// seven-segment display scanner.
//
// Optional feature: define SEG_SCAN_EN to build the display scanner. With the
// macro undefined, seg and dig_sel are tied to zero and no scanner logic is
// built; the ports stay in place.
//
// Handshake: load is a level-sampled request. When the block is idle
// (busy=0), load=1 at a rising clk edge captures bin_in and starts a
// conversion. While busy=1, load is ignored and nothing is queued. done pulses
// for exactly one cycle, and bcd_out holds the new result from that cycle
// until the next completion.
//
// fsm_state exposes the controller state (IDLE=0, SHIFT=1, DONE=2) for
// debug and assertion binding.

module count_bcd_conv #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic [2:0]  dig_sel,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] scratch;
  logic [7:0]  operand;
  logic [2:0]  shift_cnt;
  logic [11:0] adjusted;
  logic        last_shift;

  // Reject an out-of-range prescaler divide at elaboration time.
  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_scan_div_check
    $error("count_bcd_conv: SCAN_DIV must be within 2..65535");
  end

  // Add 3 to a BCD digit of 5 or more so the next left shift carries correctly.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      return nib + 4'd3;
    end
    return nib;
  endfunction

  // Per-digit correction applied ahead of each shift.
  always_comb begin
    adjusted = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  end

  assign last_shift = (shift_cnt == 3'd7);

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign fsm_state = state;

  // Datapath: capture in IDLE, eight correct-and-shift steps in SHIFT, and
  // publish the result on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch   <= 12'h000;
      operand   <= 8'h00;
      shift_cnt <= 3'd0;
      bcd_out   <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            operand   <= bin_in;
            scratch   <= 12'h000;
            shift_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          scratch   <= {adjusted[10:0], operand[7]};
          operand   <= {operand[6:0], 1'b0};
          shift_cnt <= shift_cnt + 3'd1;
          if (last_shift) begin
            bcd_out <= {adjusted[10:0], operand[7]};
          end
        end
        default: begin
          scratch <= scratch;
        end
      endcase
    end
  end

`ifdef SEG_SCAN_EN
  logic [15:0] prescale;
  logic [3:0]  digit;

  // Prescaler and digit rotation: each digit is shown for SCAN_DIV cycles,
  // hundreds -> tens -> ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= 16'd0;
      dig_sel  <= 3'b100;
    end else if (prescale == 16'(SCAN_DIV - 1)) begin
      prescale <= 16'd0;
      dig_sel  <= {dig_sel[0], dig_sel[2:1]};
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  // Select the digit being shown and decode it (no leading-zero blanking).
  always_comb begin
    digit = bcd_out[3:0];
    case (dig_sel)
      3'b100:  digit = bcd_out[11:8];
      3'b010:  digit = bcd_out[7:4];
      default: digit = bcd_out[3:0];
    endcase
    seg = 7'h00;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end
`else
  assign seg     = 7'h00;
  assign dig_sel = 3'b000;
`endif

endmodule

// File: tb/tb_count_bcd_conv.sv
// tb_count_bcd_conv: self-checking bench for count_bcd_conv. It uses a
// vector table, hand-written corner-case sequences, and randomized values
// checked against an arithmetic decimal model.

module tb_count_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [6:0]  seg;
  logic [2:0]  dig_sel;
  logic [1:0]  fsm_state;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[10];

  count_bcd_conv #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [11:0] model(input int v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("done_without_request", {31'd0, done}, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("sb_bcd_at_done", {20'd0, bcd_out}, {20'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n  = 1'b0;
    load   = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One-cycle load, then track busy/done until the block is idle again.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp_bcd, input string tag);
    int busy_n;
    int done_n;
    int done_at;
    @(posedge clk);
    #1;
    load   = 1'b1;
    bin_in = v;
    exp_q.push_back(exp_bcd);
    @(posedge clk);
    #1;
    load   = 1'b0;
    bin_in = 8'($urandom);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
      end
      if (!busy) break;
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
    check({tag, "_done_cycles"}, 32'(done_n), 32'd1);
    check({tag, "_done_latency"}, 32'(done_at), 32'd8);
    check({tag, "_bcd_hold"}, {20'd0, bcd_out}, {20'd0, exp_bcd});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    logic [6:0] seg_tab[10];
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd128, 12'h128};
    vecs[4] = '{8'd9,   12'h009};
    vecs[5] = '{8'd10,  12'h010};
    vecs[6] = '{8'd100, 12'h100};
    vecs[7] = '{8'd199, 12'h199};
    vecs[8] = '{8'd200, 12'h200};
    vecs[9] = '{8'd5,   12'h005};

    // Reset state, sampled while reset is held.
    rst_n  = 1'b0;
    load   = 1'b0;
    bin_in = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {20'd0, bcd_out}, 32'd0);
    apply_reset();

    // Table vectors.
    foreach (vecs[k]) begin
      run_conv(vecs[k].bin, vecs[k].bcd, $sformatf("vec%0d", k));
    end

    // A load during SHIFT is ignored and the result comes from the first capture.
    @(posedge clk);
    #1;
    load   = 1'b1;
    bin_in = 8'd99;
    exp_q.push_back(model(99));
    @(posedge clk);
    #1;
    load = 1'b0;
    base = done_seen;
    repeat (2) @(posedge clk);
    #1;
    load   = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (25) @(negedge clk);
    check("ignored_load_done_count", 32'(done_seen - base), 32'd1);
    check("ignored_load_bcd", {20'd0, bcd_out}, 32'h099);

    // Reset during the 4th SHIFT cycle aborts the conversion.
    @(posedge clk);
    #1;
    load   = 1'b1;
    bin_in = 8'd128;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_bcd", {20'd0, bcd_out}, 32'd0);
    base = done_seen;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_seen - base), 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    run_conv(8'd77, model(77), "after_abort");

    // Randomized values against the decimal model.
    for (int r = 0; r < 20; r++) begin
      int v;
      v = int'($urandom_range(0, 255));
      run_conv(8'(v), model(v), $sformatf("rand%0d", r));
    end

    // Load held high while bin_in sweeps: a capture every 10 cycles.
    base = done_seen;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      load   = 1'b1;
      bin_in = 8'(k);
      if (k % 10 == 0) exp_q.push_back(model(k));
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (15) @(negedge clk);
    check("sweep_done_count", 32'(done_seen - base), 32'd3);
    check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef SEG_SCAN_EN
    // Scanner with bcd_out = 128: four cycles per digit, hundreds first.
    run_conv(8'd128, model(128), "scan_load");
    begin
      logic [2:0] prev;
      logic       found;
      logic [11:0] b;
      prev  = dig_sel;
      found = 1'b0;
      b     = model(128);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (dig_sel == 3'b100 && prev != 3'b100) begin
          found = 1'b1;
          break;
        end
        prev = dig_sel;
      end
      check("scan_sync_found", {31'd0, found}, 32'd1);
      for (int j = 0; j < 12; j++) begin
        logic [2:0] ed;
        logic [3:0] nib;
        if (j > 0) @(negedge clk);
        case (j / 4)
          0: begin ed = 3'b100; nib = b[11:8]; end
          1: begin ed = 3'b010; nib = b[7:4]; end
          default: begin ed = 3'b001; nib = b[3:0]; end
        endcase
        check($sformatf("scan_dig_%0d", j), {29'd0, dig_sel}, {29'd0, ed});
        check($sformatf("scan_seg_%0d", j), {25'd0, seg}, {25'd0, seg_tab[nib]});
      end
    end
`else
    check("noscan_seg", {25'd0, seg}, 32'd0);
    check("noscan_dig", {29'd0, dig_sel}, 32'd0);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
